// File: rtl/fifo_ctrl_if.sv
// Handshake bundle between the FIFO controller, the board-level requester and the RegisterFile.
// The slave modport is the controller's view; the master modport is the surrounding logic.
interface fifo_ctrl_if #(
    parameter int M = 3,
    parameter int N = 4
);
    logic         En_In;
    logic         En_Out;
    logic [N-1:0] In;
    logic [N-1:0] Read_Data;
    logic [M-1:0] Read_Address;
    logic [M-1:0] Write_Address;
    logic [N-1:0] Write_Data;
    logic         Write_Enable;
    logic [N-1:0] Out;
    logic         Out_Valid;
    logic         Empty;
    logic         Full;
    logic [M-1:0] Count;

    modport slave (
        input  En_In, En_Out, In, Read_Data,
        output Read_Address, Write_Address, Write_Data, Write_Enable,
        output Out, Out_Valid, Empty, Full, Count
    );

    modport master (
        output En_In, En_Out, In, Read_Data,
        input  Read_Address, Write_Address, Write_Data, Write_Enable,
        input  Out, Out_Valid, Empty, Full, Count
    );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO controller that uses a RegisterFile (address 0 hardwired to zero) as storage.
// Holds head/tail/count, edge-detects the request levels and registers the output word and flags.
module fifo_ctrl #(
    parameter int M = 3,
    parameter int N = 4
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    fifo_ctrl_if.slave  bus
);
    localparam logic [M-1:0] PTR_FIRST = M'(1);
    localparam logic [M-1:0] PTR_LAST  = {M{1'b1}};
    localparam logic [M-1:0] CNT_ONE   = M'(1);

    logic         en_in_d, en_out_d;
    logic         in_pulse, out_pulse;
    logic         do_enq, do_deq;
    logic [M-1:0] head, tail, count;
    logic [M-1:0] count_nxt;
    logic [N-1:0] out_r;
    logic         out_valid_r, empty_r, full_r;

    // Pointers cycle through 1..2^M-1 so the hardwired-zero address is never used.
    function automatic logic [M-1:0] ptr_next(input logic [M-1:0] p);
        return (p == PTR_LAST) ? PTR_FIRST : p + CNT_ONE;
    endfunction

    assign in_pulse  = bus.En_In  & ~en_in_d;
    assign out_pulse = bus.En_Out & ~en_out_d;

    // When full, a simultaneous dequeue frees the slot, so the write may proceed onto head.
    always_comb begin
        do_enq    = in_pulse  & (~full_r | out_pulse);
        do_deq    = out_pulse & ~empty_r;
        count_nxt = count;
        if (do_enq && !do_deq)
            count_nxt = count + CNT_ONE;
        else if (do_deq && !do_enq)
            count_nxt = count - CNT_ONE;
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            en_in_d     <= 1'b0;
            en_out_d    <= 1'b0;
            head        <= PTR_FIRST;
            tail        <= PTR_FIRST;
            count       <= '0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
            empty_r     <= 1'b1;
            full_r      <= 1'b0;
        end else begin
            en_in_d     <= bus.En_In;
            en_out_d    <= bus.En_Out;
            out_valid_r <= do_deq;
            count       <= count_nxt;
            empty_r     <= (count_nxt == '0);
            full_r      <= (count_nxt == PTR_LAST);
            if (do_enq)
                tail <= ptr_next(tail);
            if (do_deq) begin
                head  <= ptr_next(head);
                out_r <= bus.Read_Data;
            end
        end
    end

    // Gating with reset keeps a request that is high during reset from strobing the RegisterFile.
    assign bus.Write_Enable  = do_enq & ~reset;
    assign bus.Write_Address = tail;
    assign bus.Write_Data    = bus.In;
    assign bus.Read_Address  = head;
    assign bus.Out           = out_r;
    assign bus.Out_Valid     = out_valid_r;
    assign bus.Empty         = empty_r;
    assign bus.Full          = full_r;
    assign bus.Count         = count;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a small RegisterFile model (address 0 reads zero).
`timescale 1ns/1ps
module tb_fifo_ctrl;
    logic CLK100MHZ = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [3:0] mem [0:7];
    int         we_cnt;
    int         ov_cnt;
    int         we_addr [$];
    int         out_log [$];

    fifo_ctrl_if #(.M(3), .N(4)) bus ();

    fifo_ctrl #(.M(3), .N(4)) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .bus       (bus.slave)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    assign bus.Read_Data = mem[bus.Read_Address];

    always @(posedge CLK100MHZ)
        if (bus.Write_Enable && bus.Write_Address != 3'd0)
            mem[bus.Write_Address] <= bus.Write_Data;

    // Inputs change 2 ns after posedge, so negedge sampling is clear of both edges.
    always @(negedge CLK100MHZ) begin
        if (bus.Write_Enable) begin
            we_cnt++;
            we_addr.push_back(int'(bus.Write_Address));
        end
        if (bus.Out_Valid) begin
            ov_cnt++;
            out_log.push_back(int'(bus.Out));
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK100MHZ);
        #2;
    endtask

    task automatic clear_logs();
        we_cnt = 0;
        ov_cnt = 0;
        we_addr.delete();
        out_log.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        clear_logs();
    endtask

    task automatic enq(input int val, input int hold);
        bus.In    = 4'(val);
        bus.En_In = 1'b1;
        tick(hold);
        bus.En_In = 1'b0;
        tick(1);
    endtask

    task automatic deq(input int hold);
        bus.En_Out = 1'b1;
        tick(hold);
        bus.En_Out = 1'b0;
        tick(1);
    endtask

    task automatic both(input int val);
        bus.In     = 4'(val);
        bus.En_In  = 1'b1;
        bus.En_Out = 1'b1;
        tick(1);
        bus.En_In  = 1'b0;
        bus.En_Out = 1'b0;
        tick(1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 4'd0;
        bus.En_In  = 1'b0;
        bus.En_Out = 1'b0;
        bus.In     = 4'd0;
        reset      = 1'b1;
        clear_logs();
        tick(2);

        // 1: reset state, including a request held high through reset
        bus.En_In = 1'b1;
        bus.In    = 4'd6;
        @(negedge CLK100MHZ);
        check("rst_empty", int'(bus.Empty), 1);
        check("rst_full", int'(bus.Full), 0);
        check("rst_count", int'(bus.Count), 0);
        check("rst_out", int'(bus.Out), 0);
        check("rst_raddr", int'(bus.Read_Address), 1);
        check("rst_we_suppressed", int'(bus.Write_Enable), 0);
        @(posedge CLK100MHZ);
        #2;
        reset = 1'b0;
        #1;
        check("held_req_we", int'(bus.Write_Enable), 1);
        check("held_req_waddr", int'(bus.Write_Address), 1);
        tick(3);
        check("held_req_count", int'(bus.Count), 1);
        bus.En_In = 1'b0;
        tick(1);

        // 2: long-held requests produce one strobe each
        do_reset();
        enq(3, 4);
        enq(5, 4);
        enq(9, 4);
        @(negedge CLK100MHZ);
        check("t2_we_cnt", we_cnt, 3);
        for (int i = 0; i < 3; i++) check("t2_waddr", we_addr[i], i + 1);
        check("t2_count", int'(bus.Count), 3);
        check("t2_empty", int'(bus.Empty), 0);
        check("t2_mem3", int'(mem[3]), 9);

        // 3: fill to 7, then a refused 8th enqueue
        do_reset();
        for (int v = 1; v <= 7; v++) enq(v, 1);
        @(negedge CLK100MHZ);
        check("t3_full", int'(bus.Full), 1);
        check("t3_count", int'(bus.Count), 7);
        for (int i = 0; i < 7; i++) check("t3_waddr", we_addr[i], i + 1);
        enq(15, 2);
        @(negedge CLK100MHZ);
        check("t3_refused_we", we_cnt, 7);
        check("t3_refused_count", int'(bus.Count), 7);

        // 4: drain 7 in order, 8th dequeue refused
        clear_logs();
        for (int i = 0; i < 8; i++) deq(2);
        @(negedge CLK100MHZ);
        check("t4_ov_cnt", ov_cnt, 7);
        for (int i = 0; i < 7; i++) check("t4_out_order", out_log[i], i + 1);
        check("t4_empty", int'(bus.Empty), 1);
        check("t4_count", int'(bus.Count), 0);
        check("t4_out_hold", int'(bus.Out), 7);

        // 5: wrap past the hardwired address
        clear_logs();
        enq(10, 1);
        check("t5_waddr_wrap", we_addr[0], 1);
        deq(1);
        @(negedge CLK100MHZ);
        check("t5_out", int'(bus.Out), 10);
        check("t5_ov_cnt", ov_cnt, 1);

        // 6a: simultaneous while full
        do_reset();
        for (int v = 1; v <= 7; v++) enq(v, 1);
        clear_logs();
        both(8);
        @(negedge CLK100MHZ);
        check("t6a_out", out_log[0], 1);
        check("t6a_waddr", we_addr[0], 1);
        check("t6a_mem1", int'(mem[1]), 8);
        check("t6a_count", int'(bus.Count), 7);
        check("t6a_full", int'(bus.Full), 1);

        // 6b: simultaneous while empty
        do_reset();
        both(4);
        @(negedge CLK100MHZ);
        check("t6b_ov_cnt", ov_cnt, 0);
        check("t6b_count", int'(bus.Count), 1);
        check("t6b_empty", int'(bus.Empty), 0);

        // 6c: asynchronous reset with three entries queued
        enq(2, 1);
        enq(3, 1);
        @(negedge CLK100MHZ);
        check("t6c_count_pre", int'(bus.Count), 3);
        #1;
        reset = 1'b1;
        #1;
        check("t6c_count", int'(bus.Count), 0);
        check("t6c_empty", int'(bus.Empty), 1);
        check("t6c_head", int'(bus.Read_Address), 1);
        check("t6c_tail", int'(bus.Write_Address), 1);
        tick(1);
        reset = 1'b0;
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Queue controller placed directly upstream of the RegisterFile.
- Turns board-level enqueue/dequeue requests into register-file write-port and read-port traffic, using the register file as FIFO storage.
- Address 0 of the register file is hardwired to zero, so storage is entries 1..2^M-1 and FIFO depth is 2^M-1.
- Keeps head/tail pointers and the occupancy count, and presents a registered output word plus status flags.

Parameters:
- M, 3: register-file address width; FIFO depth is 2^M-1 (7 at default).
- N, 4: data width.

Ports:
- CLK100MHZ  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- En_In  input  1  enqueue request level; acts on rising edge only
- En_Out  input  1  dequeue request level; acts on rising edge only
- In  input  N  data to enqueue
- Read_Data  input  N  from RegisterFile Read_Data_0 (combinational read of Read_Address)
- Read_Address  output  M  to RegisterFile Read_Address_0; always equals head
- Write_Address  output  M  to RegisterFile Write_Address; equals tail
- Write_Data  output  N  to RegisterFile Write_Data; equals In
- Write_Enable  output  1  to RegisterFile Write_Enable; one-cycle write strobe
- Out  output  N  last dequeued word, registered
- Out_Valid  output  1  one-cycle pulse in the cycle after a dequeue
- Empty  output  1  count == 0
- Full  output  1  count == 2^M-1
- Count  output  M  occupancy, 0..2^M-1

Behaviour:
- Clock and reset: reset is asynchronous, active-high; all state is clocked on posedge CLK100MHZ.
- Reset values:
  - head = tail = 1, count = 0.
  - Out = 0, Out_Valid = 0, Empty = 1, Full = 0.
  - Edge-detect delay flops = 0.
  - Write_Enable = 0.
- Edge detect:
  - in_pulse = En_In & ~En_In_d; out_pulse = En_Out & ~En_Out_d (both delay flops cleared by reset).
  - A request held for many cycles produces exactly one operation.
  - A request already high when reset deasserts yields one operation on the first clock after deassertion.
- Pointer advance: 1,2,...,2^M-1, then back to 1; address 0 is never produced.
- Enqueue (in_pulse & ~Full):
  - Write_Enable = 1 combinationally during the pulse cycle, with Write_Address = tail and Write_Data = In.
  - At the clock edge, tail advances and count increments.
- Enqueue refused (in_pulse & Full): Write_Enable stays 0; tail and count are unchanged.
- Dequeue (out_pulse & ~Empty):
  - At the clock edge, Out <= Read_Data (value at head), head advances, count decrements.
  - Out_Valid = 1 for the following cycle only.
- Dequeue refused (out_pulse & Empty): Out holds its value, Out_Valid stays 0, head is unchanged.
- Simultaneous in_pulse & out_pulse:
  - Empty: enqueue only; no dequeue and no Out_Valid.
  - Full: both proceed. Write and read hit the same address; Out captures the old value, because the read is combinational and the write lands at the edge. count stays 2^M-1.
  - Otherwise: both proceed; count unchanged.
- Latency: enqueue to visible at Read_Data is 1 cycle; dequeue pulse to Out valid is 1 cycle.
- Flags: Empty, Full and Count are registered, derived from count, and change in the cycle after the operation.
- Reset mid-operation:
  - All controller state returns to reset values immediately.
  - Register-file contents are irrelevant, because count = 0.
  - A write strobe coincident with reset assertion is suppressed.

Test Plan (M=3, N=4, controller connected to RegisterFile):
1. Assert reset -> Empty=1, Full=0, Count=0, Out=0, Read_Address=1, Write_Enable=0.
2. Enqueue 3, 5, 9 with En_In held 4 cycles each -> exactly three 1-cycle Write_Enable strobes at addresses 1, 2, 3; Count=3, Empty=0.
3. From reset, enqueue 1..7, then an 8th value 0xF -> writes at addresses 1..7, Full=1, Count=7; 8th request gives no Write_Enable and Count stays 7.
4. Continue from 3: dequeue 8 times -> Out = 1,2,...,7 in order, each with a 1-cycle Out_Valid; Empty=1 after the 7th; 8th gives no Out_Valid and Out holds 7.
5. Continue from 4: enqueue 0xA -> Write_Address = 1 (wrap skips 0); a following dequeue gives Out=0xA.
6. Simultaneous and reset cases:
   - Full (values 1..7), pulse both with In=8 -> Out=1, address 1 written with 8, Count=7.
   - Empty, pulse both with In=4 -> no Out_Valid, Count=1.
   - Assert reset with Count=3 -> Count=0, Empty=1, head=tail=1.
